// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS core: sequences the shared memory/ALU datapath
// and stalls FETCH/MEMRD/MEMWR on the memory-ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   0     | FETCH    read instruction at PC, PC <= PC+4
//   1     | DECODE   branch target into ALUOut, dispatch on opcode
//   2     | MEMADR   effective address for lw/sw
//   3     | MEMRD    load data read into MDR
//   4     | MEMWB    write MDR to rt
//   5     | MEMWR    store B at ALUOut
//   6     | EXECUTE  R-type ALU operation
//   7     | ALUWB    write ALUOut to rd
//   8     | BRANCH   compare A/B, conditionally load PC from ALUOut
//   9     | ADDIEXEC A + sign-extended immediate
//   10    | ADDIWB   write ALUOut to rt
//   11    | JUMP     PC <= jump target
module multicycle_controller #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       i_or_d_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dest_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] alu_ctrl_o,
    output logic       pc_en_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       i_or_d;
        logic       fetch;      // ir_write and pc_write qualified by mem_ready
        logic       mem_write;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       pc_write;
        logic       branch;
        logic       beq_sel;
    } ctrl_t;

    function automatic logic [2:0] alu_decode(input logic [5:0] funct);
        case (funct)
            6'b100000: alu_decode = 3'b010;
            6'b100010: alu_decode = 3'b110;
            6'b100100: alu_decode = 3'b000;
            6'b100101: alu_decode = 3'b001;
            6'b101010: alu_decode = 3'b111;
            default:   alu_decode = 3'b000;
        endcase
    endfunction

    // Output decode is applied to the next state so the registered outputs line up with state_q.
    function automatic ctrl_t ctrl_decode(input logic [3:0] st, input logic [5:0] funct,
                                          input logic [5:0] op);
        ctrl_t c;
        c = '0;
        c.alu_ctrl = 3'b010;
        case (st)
            S_FETCH:    begin c.alu_src_b = 2'b01; c.fetch = 1'b1; end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:    c.i_or_d = 1'b1;
            S_MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:    begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_ctrl = alu_decode(funct); end
            S_ALUWB:    begin c.reg_write = 1'b1; c.reg_dest = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = 3'b110;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
                c.beq_sel   = (op == OP_BEQ);
            end
            S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB:   c.reg_write = 1'b1;
            S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    logic [3:0] state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       ready;

    assign ready = !USE_MEM_READY || mem_ready_i;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEXEC;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = ctrl_decode(state_d, funct_i, op_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_decode(S_FETCH, 6'd0, 6'd0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign i_or_d_o     = ctrl_q.i_or_d;
    assign ir_write_o   = ctrl_q.fetch & ready;
    assign mem_write_o  = ctrl_q.mem_write;
    assign reg_write_o  = ctrl_q.reg_write;
    assign reg_dest_o   = ctrl_q.reg_dest;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign alu_src_a_o  = ctrl_q.alu_src_a;
    assign alu_src_b_o  = ctrl_q.alu_src_b;
    assign pc_src_o     = ctrl_q.pc_src;
    assign alu_ctrl_o   = ctrl_q.alu_ctrl;
    assign pc_en_o      = ctrl_q.pc_write | (ctrl_q.fetch & ready)
                        | (ctrl_q.branch & (ctrl_q.beq_sel ? zero_i : ~zero_i));
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: instruction sequences, stalls, reset and
// illegal-state recovery, all expectations hand-computed.
module tb_multicycle_controller;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [5:0] op_i, funct_i;
    logic       zero_i, mem_ready_i;
    logic       i_or_d_o, ir_write_o, mem_write_o, reg_write_o, reg_dest_o, mem_to_reg_o;
    logic       alu_src_a_o, pc_en_o;
    logic [1:0] alu_src_b_o, pc_src_o;
    logic [2:0] alu_ctrl_o;
    logic [3:0] state_o;

    int vectors     = 0;
    int miscompares = 0;
    int lw_seq [5]  = '{1, 2, 3, 4, 0};

    multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .op_i(op_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .i_or_d_o(i_or_d_o), .ir_write_o(ir_write_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .reg_dest_o(reg_dest_o), .mem_to_reg_o(mem_to_reg_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o),
        .alu_ctrl_o(alu_ctrl_o), .pc_en_o(pc_en_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_no_we(input string tag);
        chk({tag, "_ir_write"}, 8'(ir_write_o), 8'd0);
        chk({tag, "_pc_en"}, 8'(pc_en_o), 8'd0);
        chk({tag, "_reg_write"}, 8'(reg_write_o), 8'd0);
        chk({tag, "_mem_write"}, 8'(mem_write_o), 8'd0);
    endtask

    task automatic run_rtype(input logic [5:0] funct, input logic [2:0] exp_alu, input string tag);
        op_i = 6'b000000; funct_i = funct;
        tick(); chk({tag, "_s1"}, 8'(state_o), 8'd1);
        tick(); chk({tag, "_s6"}, 8'(state_o), 8'd6);
        chk({tag, "_alu_ctrl"}, 8'(alu_ctrl_o), 8'(exp_alu));
        chk({tag, "_src_a"}, 8'(alu_src_a_o), 8'd1);
        chk({tag, "_src_b"}, 8'(alu_src_b_o), 8'd0);
        tick(); chk({tag, "_s7"}, 8'(state_o), 8'd7);
        chk({tag, "_reg_dest"}, 8'(reg_dest_o), 8'd1);
        chk({tag, "_reg_write"}, 8'(reg_write_o), 8'd1);
        chk({tag, "_mem_to_reg"}, 8'(mem_to_reg_o), 8'd0);
        tick(); chk({tag, "_s0"}, 8'(state_o), 8'd0);
    endtask

    task automatic run_branch(input logic [5:0] op, input logic pc_en_z1, input string tag);
        op_i = op;
        tick(); chk({tag, "_s1"}, 8'(state_o), 8'd1);
        tick(); chk({tag, "_s8"}, 8'(state_o), 8'd8);
        chk({tag, "_pc_src"}, 8'(pc_src_o), 8'd1);
        chk({tag, "_alu_ctrl"}, 8'(alu_ctrl_o), 8'b110);
        zero_i = 1'b1; #1;
        chk({tag, "_pc_en_z1"}, 8'(pc_en_o), 8'(pc_en_z1));
        zero_i = 1'b0; #1;
        chk({tag, "_pc_en_z0"}, 8'(pc_en_o), 8'(!pc_en_z1));
        tick(); chk({tag, "_s0"}, 8'(state_o), 8'd0);
    endtask

    initial begin
        reset_i = 1'b1; op_i = '0; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        chk("init_state", 8'(state_o), 8'd0);

        // reset in the middle of a stalled store
        op_i = 6'b101011;
        tick(); tick(); tick();
        chk("sw_s5", 8'(state_o), 8'd5);
        mem_ready_i = 1'b0;
        tick();
        chk("sw_stall_s5", 8'(state_o), 8'd5);
        chk("sw_stall_mem_write", 8'(mem_write_o), 8'd1);
        chk("sw_stall_i_or_d", 8'(i_or_d_o), 8'd1);
        reset_i = 1'b1;
        tick();
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_mem_write", 8'(mem_write_o), 8'd0);
        tick(); tick();
        reset_i = 1'b0; mem_ready_i = 1'b1; #1;
        chk("rst_fetch_src_b", 8'(alu_src_b_o), 8'b01);
        chk("rst_fetch_src_a", 8'(alu_src_a_o), 8'd0);
        chk("rst_fetch_i_or_d", 8'(i_or_d_o), 8'd0);
        chk("rst_fetch_pc_src", 8'(pc_src_o), 8'd0);
        chk("rst_fetch_alu_ctrl", 8'(alu_ctrl_o), 8'b010);
        chk("rst_fetch_ir_write", 8'(ir_write_o), 8'd1);
        chk("rst_fetch_pc_en", 8'(pc_en_o), 8'd1);

        // lw, no stalls
        op_i = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lw_state", 8'(state_o), 8'(lw_seq[i]));
            chk("lw_reg_write", 8'(reg_write_o), 8'(lw_seq[i] == 4));
            chk("lw_mem_to_reg", 8'(mem_to_reg_o), 8'(lw_seq[i] == 4));
            chk("lw_i_or_d", 8'(i_or_d_o), 8'(lw_seq[i] == 3));
        end

        run_rtype(6'b100000, 3'b010, "r_add");
        run_rtype(6'b101010, 3'b111, "r_slt");
        run_rtype(6'b100010, 3'b110, "r_sub");
        run_rtype(6'b110000, 3'b000, "r_unk");

        run_branch(6'b000100, 1'b1, "beq");
        run_branch(6'b000101, 1'b0, "bne");

        op_i = 6'b000010;
        tick(); chk("j_s1", 8'(state_o), 8'd1);
        tick(); chk("j_s11", 8'(state_o), 8'd11);
        chk("j_pc_src", 8'(pc_src_o), 8'b10);
        chk("j_pc_en", 8'(pc_en_o), 8'd1);
        tick(); chk("j_s0", 8'(state_o), 8'd0);

        op_i = 6'b001000;
        tick(); chk("addi_s1", 8'(state_o), 8'd1);
        tick(); chk("addi_s9", 8'(state_o), 8'd9);
        chk("addi_src_b", 8'(alu_src_b_o), 8'b10);
        tick(); chk("addi_s10", 8'(state_o), 8'd10);
        chk("addi_reg_dest", 8'(reg_dest_o), 8'd0);
        chk("addi_reg_write", 8'(reg_write_o), 8'd1);
        tick(); chk("addi_s0", 8'(state_o), 8'd0);

        // FETCH stall 3 cycles, then lw with one MEMRD stall
        op_i = 6'b100011; mem_ready_i = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("fstall_state", 8'(state_o), 8'd0);
            chk("fstall_ir_write", 8'(ir_write_o), 8'd0);
            chk("fstall_pc_en", 8'(pc_en_o), 8'd0);
            tick();
        end
        mem_ready_i = 1'b1; #1;
        chk("fstall_release_ir_write", 8'(ir_write_o), 8'd1);
        tick(); chk("fstall_adv_s1", 8'(state_o), 8'd1);
        tick(); chk("lws_s2", 8'(state_o), 8'd2);
        mem_ready_i = 1'b0;
        tick(); chk("lws_s3", 8'(state_o), 8'd3);
        tick(); chk("lws_stall_s3", 8'(state_o), 8'd3);
        chk_no_we("lws_stall");
        mem_ready_i = 1'b1;
        tick(); chk("lws_s4", 8'(state_o), 8'd4);
        tick(); chk("lws_s0", 8'(state_o), 8'd0);

        // unknown opcode behaves as NOP
        op_i = 6'b111111;
        tick(); chk("nop_s1", 8'(state_o), 8'd1);
        chk_no_we("nop_decode");
        tick(); chk("nop_s0", 8'(state_o), 8'd0);

        // illegal state recovery
        force dut.state_q = 4'd13;
        #1;
        chk("ill_state_d", 8'(dut.state_d), 8'd0);
        release dut.state_q;
        mem_ready_i = 1'b0;
        tick(); chk("ill_recover_s0", 8'(state_o), 8'd0);
        mem_ready_i = 1'b1;
        tick(); chk("ill_then_s1", 8'(state_o), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
